// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 emulator: FSM states, frame width, checksum and frame assembly.
package dht11_pkg;

    localparam int FRAME_W = 40;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HOST_LOW  = 4'd1,
        RESP_WAIT = 4'd2,
        ACK_LOW   = 4'd3,
        ACK_HIGH  = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        END_LOW   = 4'd7,
        END_REL   = 4'd8
    } state_t;

    // 8-bit sum, carry dropped, exactly as the sensor reports it.
    function automatic logic [7:0] checksum(input logic [15:0] hum, input logic [15:0] temp);
        return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] hum,
                                                       input logic [15:0] temp,
                                                       input logic        bad_sum);
        logic [7:0] sum;
        sum = checksum(hum, temp);
        if (bad_sum) sum = ~sum;
        return {hum, temp, sum};
    endfunction

endpackage

// File: rtl/dht11_emulator_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, free running.
// Latency: tick is decoded combinationally from the counter; no backpressure.
module us_tick_gen #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(CLKS_PER_US - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(CLKS_PER_US - 1));

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 sensor-side responder: accepts a host start pulse, answers with ACK and a 40-bit frame.
// Line input is 2-FF synchronized; DHT11_EMU_FAULT_EN adds i_Fault for injected protocol faults.
module dht11_emulator
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_US        = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    inout  wire         dht11,
    input  logic [15:0] i_Humidity,
    input  logic [15:0] i_Temperature,
`ifdef DHT11_EMU_FAULT_EN
    input  logic [1:0]  i_Fault,
`endif
    output logic        o_Busy,
    output logic        o_Frame_Done,
    output logic [3:0]  debug_state
);

    state_t state, state_n;

    logic               line_s1, line_s2, line_q;
    logic               fall, rise, tick;
    logic               drive_low, expire, accept, last_bit, trunc;
    logic [15:0]        us_cnt, us_inc, host_len, dur;
    logic [5:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [1:0]         fault;

`ifdef DHT11_EMU_FAULT_EN
    assign fault = i_Fault;
`else
    assign fault = 2'b00;
`endif

    us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk  (i_Clock),
        .rst  (i_Reset),
        .tick (tick)
    );

    // Synchronizer resets to the idle (pulled-up) level so reset never fakes an edge.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            line_s1 <= 1'b1;
            line_s2 <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            line_s1 <= dht11;
            line_s2 <= line_s1;
            line_q  <= line_s2;
        end
    end

    assign fall = line_q & ~line_s2;
    assign rise = ~line_q & line_s2;

    assign us_inc   = (us_cnt == 16'hFFFF) ? us_cnt : us_cnt + 16'd1;
    assign host_len = tick ? us_inc : us_cnt;

    always_comb begin
        dur = 16'd1;
        case (state)
            RESP_WAIT:         dur = 16'(RESP_DELAY_US);
            ACK_LOW, ACK_HIGH: dur = 16'(ACK_US);
            BIT_LOW, END_LOW:  dur = 16'(BIT_LOW_US);
            BIT_HIGH:          dur = shreg[FRAME_W-1] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
            default:           dur = 16'd1;
        endcase
    end

    assign expire   = tick && (us_cnt >= dur - 16'd1);
    assign last_bit = (bit_cnt == (trunc ? 6'd19 : 6'd39));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE:      if (fall) state_n = HOST_LOW;
            HOST_LOW: begin
                if (rise) begin
                    if (host_len >= 16'(START_MIN_US) && fault != 2'b10) begin
                        state_n = RESP_WAIT;
                        accept  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RESP_WAIT: if (expire) state_n = ACK_LOW;
            ACK_LOW:   if (expire) state_n = ACK_HIGH;
            ACK_HIGH:  if (expire) state_n = BIT_LOW;
            BIT_LOW:   if (expire) state_n = BIT_HIGH;
            BIT_HIGH:  if (expire) state_n = last_bit ? END_LOW : BIT_LOW;
            END_LOW:   if (expire) state_n = END_REL;
            END_REL:   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Every transition restarts the phase timer; IDLE holds it at zero.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            us_cnt       <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            trunc        <= 1'b0;
            o_Frame_Done <= 1'b0;
        end else begin
            o_Frame_Done <= (state == END_REL);
            if (state_n != state) begin
                us_cnt <= '0;
            end else if (tick && state != IDLE) begin
                us_cnt <= us_inc;
            end
            if (accept) begin
                shreg   <= build_frame(i_Humidity, i_Temperature, fault == 2'b01);
                bit_cnt <= '0;
                trunc   <= (fault == 2'b11);
            end else if (state == BIT_HIGH && expire) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    assign drive_low   = (state == ACK_LOW) || (state == BIT_LOW) || (state == END_LOW);
    assign dht11       = drive_low ? 1'b0 : 1'bz;
    assign o_Busy      = (state != IDLE) && (state != HOST_LOW);
    assign debug_state = state;

endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator: host stimulus on a pulled-up line, waveform model built from protocol timings.
module tb_dht11_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_low = 1'b0;
    logic [15:0] hum = 16'h0000;
    logic [15:0] temp = 16'h0000;
`ifdef DHT11_EMU_FAULT_EN
    logic [1:0]  fault = 2'b00;
`endif
    wire         line;
    logic        busy, done;
    logic [3:0]  dbg;

    assign line = host_low ? 1'b0 : 1'bz;
    pullup (line);

    dht11_emulator #(.CLKS_PER_US(1), .START_MIN_US(100)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .dht11         (line),
        .i_Humidity    (hum),
        .i_Temperature (temp),
`ifdef DHT11_EMU_FAULT_EN
        .i_Fault       (fault),
`endif
        .o_Busy        (busy),
        .o_Frame_Done  (done),
        .debug_state   (dbg)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    int          cyc_now = 0, rel_cyc = 0, rise_cyc = 0;
    bit          exp_lvl[$];
    int          widx = 0, run_no = 0, run_len = 0, dec_n = 0;
    bit          run = 0, frame_fin = 0, frame_expected = 0, busy_d = 0, last_lvl = 1;
    int          wave_err = 0, idle_err = 0, busy_rises = 0, unexp_busy = 0, done_cnt = 0;
    logic [39:0] dec_bits = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t, input bit inv);
        int         s;
        logic [7:0] c;
        s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
        c = 8'(s % 256);
        if (inv) c = ~c;
        return {h, t, c};
    endfunction

    // Expected line level per cycle, starting with the first busy cycle.
    task automatic make_wave(input logic [39:0] f, input int nbits);
        exp_lvl.delete();
        repeat (30) exp_lvl.push_back(1'b1);
        repeat (80) exp_lvl.push_back(1'b0);
        repeat (80) exp_lvl.push_back(1'b1);
        for (int i = 0; i < nbits; i++) begin
            repeat (50) exp_lvl.push_back(1'b0);
            repeat (f[39-i] ? 70 : 27) exp_lvl.push_back(1'b1);
        end
        repeat (50) exp_lvl.push_back(1'b0);
        exp_lvl.push_back(1'b1);
    endtask

    task automatic host_pulse(input int len);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (len) @(posedge clk);
        #1 host_low = 1'b0;
        rel_cyc = cyc_now;
    endtask

    // Compare process: line is the wired-AND of the model's emulator level and the host drive.
    initial forever begin
        @(negedge clk);
        cyc_now++;
        if (rst) begin
            run    = 0;
            busy_d = 0;
        end else begin
            if (done) done_cnt++;
            if (busy && !busy_d) begin
                busy_rises++;
                rise_cyc = cyc_now;
                if (frame_expected && !run) begin
                    run = 1; frame_expected = 0; widx = 0; run_no = 0; run_len = 0;
                    last_lvl = 1; dec_bits = '0; dec_n = 0;
                end else begin
                    unexp_busy++;
                end
            end
            busy_d = busy;
            if (run) begin
                if (widx < exp_lvl.size()) begin
                    if (busy !== 1'b1 || line !== (exp_lvl[widx] & !host_low)) wave_err++;
                    if (line !== last_lvl) begin
                        if (last_lvl && run_no >= 4 && run_no % 2 == 0) begin
                            dec_bits = {dec_bits[38:0], run_len > 48};
                            dec_n++;
                        end
                        run_no++;
                        run_len  = 0;
                        last_lvl = line;
                    end
                    run_len++;
                end else begin
                    if (busy !== 1'b0 || done !== 1'b1) wave_err++;
                    run       = 0;
                    frame_fin = 1;
                end
                widx++;
            end else if (line !== !host_low) begin
                idle_err++;
            end
        end
    end

    // mode 0: plain frame, 1: inputs change mid-frame, 2: host pulls low across released phases.
    task automatic do_frame(input string nm, input logic [39:0] f, input int nbits,
                            input int low_len, input int mode);
        int d0, cyc;
        d0 = done_cnt;
        make_wave(f, nbits);
        wave_err = 0; idle_err = 0; unexp_busy = 0; frame_fin = 0; frame_expected = 1;
        host_pulse(low_len);
        cyc = 0;
        while (!frame_fin && cyc < 8000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 1 && run && widx == 600) begin
                hum  = 16'hAAAA;
                temp = 16'h5555;
            end
            if (mode == 2 && run && widx == 100) host_low = 1'b1;
            if (mode == 2 && run && widx == 220) host_low = 1'b0;
        end
        host_low = 1'b0;
        frame_expected = 0;
        repeat (3) @(negedge clk);
        check({nm, " completed"}, frame_fin, 1);
        check({nm, " accept latency"}, (rise_cyc - rel_cyc >= 3) && (rise_cyc - rel_cyc <= 5), 1);
        check({nm, " waveform"}, wave_err, 0);
        if (mode != 2) begin
            check({nm, " bit count"}, dec_n, nbits);
            check({nm, " decoded"}, dec_bits, f >> (40 - nbits));
        end
        check({nm, " done pulses"}, done_cnt - d0, 1);
        check({nm, " stray busy"}, unexp_busy, 0);
        check({nm, " idle line"}, idle_err, 0);
    endtask

    task automatic no_frame(input string nm, input int low_len);
        int r0, d0;
        r0 = busy_rises; d0 = done_cnt; idle_err = 0; frame_expected = 0;
        host_pulse(low_len);
        repeat (250) @(negedge clk);
        check({nm, " no busy"}, busy_rises - r0, 0);
        check({nm, " line released"}, idle_err, 0);
        check({nm, " no done"}, done_cnt - d0, 0);
        check({nm, " idle state"}, dbg, 0);
    endtask

    initial begin
        logic [39:0] f1;
        int          tgt, cyc, d0, r0;

        repeat (3) @(negedge clk);
        check("reset line", line, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset state", dbg, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        hum = 16'h3700; temp = 16'h1905;
        f1  = model_frame(hum, temp, 0);
        check("model frame normal", f1, 40'h3700190555);
        do_frame("normal", f1, 40, 120, 0);

        hum = 16'hFFFF; temp = 16'h0102;
        check("model frame wrap", model_frame(hum, temp, 0), 40'hFFFF010201);
        do_frame("checksum wrap", model_frame(hum, temp, 0), 40, 120, 0);

        no_frame("short 50", 50);
        no_frame("short 99", 99);
        do_frame("exact 100", model_frame(hum, temp, 0), 40, 100, 0);

        // Reset while the emulator is driving the low preamble of bit 12.
        hum = 16'h3700; temp = 16'h1905;
        make_wave(f1, 40);
        wave_err = 0; frame_fin = 0; frame_expected = 1; d0 = done_cnt;
        host_pulse(120);
        tgt = 190;
        for (int i = 0; i < 12; i++) tgt += 50 + (f1[39-i] ? 70 : 27);
        tgt += 20;
        cyc = 0;
        while (!(run && widx >= tgt) && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("pre-reset drive", line, 0);
        check("pre-reset waveform", wave_err, 0);
        rst = 1'b1;
        #1;
        check("reset releases line", line, 1);
        check("reset state idle", dbg, 0);
        check("reset busy low", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        frame_expected = 0;
        r0 = busy_rises;
        repeat (300) @(negedge clk);
        check("reset no done", done_cnt - d0, 0);
        check("reset no restart", busy_rises - r0, 0);
        do_frame("after reset", f1, 40, 120, 0);

        hum = 16'h1234; temp = 16'h5678;
        check("model frame snapshot", model_frame(hum, temp, 0), 40'h1234567814);
        do_frame("snapshot", model_frame(hum, temp, 0), 40, 120, 1);

        hum = 16'h3700; temp = 16'h1905;
        do_frame("host pulse mid-frame", f1, 40, 120, 2);

`ifdef DHT11_EMU_FAULT_EN
        fault = 2'b01;
        check("model frame inverted", model_frame(hum, temp, 1), 40'h37001905AA);
        do_frame("fault 01", model_frame(hum, temp, 1), 40, 120, 0);
        fault = 2'b10;
        no_frame("fault 10", 120);
        fault = 2'b11;
        do_frame("fault 11", f1, 20, 120, 0);
        fault = 2'b00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
